// File: rtl/vec_lsu_agen_if.sv
// Per-beat request bus between vec_lsu_agen (master) and mem_queue (slave),
// including mem_queue's load/store completion indications.
interface vec_lsu_agen_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int DW_B       = DATA_WIDTH >> 3
);
  logic [ADDR_WIDTH-1:0] rvv_addr_out;
  logic [DATA_WIDTH-1:0] rvv_data_out;
  logic                  rvv_valid_out;
  logic                  rvv_req_out;
  logic                  rvv_start_out;
  logic [DW_B-1:0]       rvv_be_out;
  logic                  rvv_done_ld;
  logic                  rvv_done_st;

  modport master (
    output rvv_addr_out, rvv_data_out, rvv_valid_out, rvv_req_out,
    output rvv_start_out, rvv_be_out,
    input  rvv_done_ld, rvv_done_st
  );

  modport slave (
    input  rvv_addr_out, rvv_data_out, rvv_valid_out, rvv_req_out,
    input  rvv_start_out, rvv_be_out,
    output rvv_done_ld, rvv_done_st
  );
endinterface

// File: rtl/vec_lsu_agen.sv
// Vector load/store address generator: expands one strided vector memory command
// into per-beat requests for mem_queue and retires it on mem_queue completion.
module vec_lsu_agen #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int DW_B       = DATA_WIDTH >> 3,
  parameter int BEAT_BITS  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_store,
  input  logic [ADDR_WIDTH-1:0] cmd_base,
  input  logic [ADDR_WIDTH-1:0] cmd_stride,
  input  logic [BEAT_BITS-1:0]  cmd_beats,
  input  logic [DW_B-1:0]       cmd_be_last,
  input  logic [DATA_WIDTH-1:0] st_data,
  input  logic                  st_valid,
  output logic                  st_ready,
  vec_lsu_agen_if.master        rvv,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOAD_REQ   = 3'd1,
    LOAD_WAIT  = 3'd2,
    STORE      = 3'd3,
    STORE_WAIT = 3'd4,
    FIN        = 3'd5
  } state_t;

  localparam logic [DW_B-1:0]      BE_ALL    = {DW_B{1'b1}};
  localparam logic [BEAT_BITS-1:0] BEAT_ZERO = {BEAT_BITS{1'b0}};
  localparam logic [BEAT_BITS-1:0] BEAT_ONE  = BEAT_BITS'(1);

  state_t                state_r;
  state_t                state_s;

  logic [ADDR_WIDTH-1:0] stride_r;
  logic [BEAT_BITS-1:0]  beats_r;
  logic [DW_B-1:0]       be_last_r;
  logic [ADDR_WIDTH-1:0] acc_r;
  logic [BEAT_BITS-1:0]  idx_r;

  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] data_r;
  logic [DW_B-1:0]       be_r;
  logic                  req_r;
  logic                  valid_r;
  logic                  start_r;
  logic                  busy_r;
  logic                  done_r;

  logic                  accept_s;
  logic                  st_fire_s;
  logic                  ld_issue_s;
  logic                  st_issue_s;
  logic [ADDR_WIDTH-1:0] beat_addr_s;
  logic [ADDR_WIDTH-1:0] beat_stride_s;
  logic [BEAT_BITS-1:0]  beat_idx_s;
  logic                  beat_last_s;

  assign cmd_ready = (state_r == IDLE);
  assign st_ready  = (state_r == STORE);
  assign accept_s  = cmd_valid & (state_r == IDLE);
  assign st_fire_s = st_valid & (state_r == STORE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (!accept_s) begin
          state_s = IDLE;
        end else if (cmd_beats == BEAT_ZERO) begin
          state_s = FIN;
        end else if (cmd_store) begin
          state_s = STORE;
        end else begin
          state_s = LOAD_REQ;
        end
      end
      LOAD_REQ: begin
        if (idx_r == beats_r) begin
          state_s = LOAD_WAIT;
        end else begin
          state_s = LOAD_REQ;
        end
      end
      LOAD_WAIT: begin
        if (rvv.rvv_done_ld) begin
          state_s = FIN;
        end else begin
          state_s = LOAD_WAIT;
        end
      end
      STORE: begin
        if (st_fire_s && (idx_r == beats_r - BEAT_ONE)) begin
          state_s = STORE_WAIT;
        end else begin
          state_s = STORE;
        end
      end
      STORE_WAIT: begin
        if (rvv.rvv_done_st) begin
          state_s = FIN;
        end else begin
          state_s = STORE_WAIT;
        end
      end
      FIN:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Beat issue decode; load beat 0 is issued on the accept edge so it appears
  // in the first LOAD_REQ cycle and the whole burst stays gapless.
  always_comb begin
    ld_issue_s    = 1'b0;
    st_issue_s    = 1'b0;
    beat_addr_s   = acc_r;
    beat_stride_s = stride_r;
    beat_idx_s    = idx_r;
    case (state_r)
      IDLE: begin
        beat_addr_s   = cmd_base;
        beat_stride_s = cmd_stride;
        beat_idx_s    = BEAT_ZERO;
        ld_issue_s    = accept_s & ~cmd_store & (cmd_beats != BEAT_ZERO);
      end
      LOAD_REQ: ld_issue_s = (idx_r != beats_r);
      STORE:    st_issue_s = st_valid;
      default:  ld_issue_s = 1'b0;
    endcase
    beat_last_s = (beat_idx_s == beats_r - BEAT_ONE);
  end

  // Command latch, address/beat counters and registered request outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      stride_r  <= {ADDR_WIDTH{1'b0}};
      beats_r   <= BEAT_ZERO;
      be_last_r <= {DW_B{1'b0}};
      acc_r     <= {ADDR_WIDTH{1'b0}};
      idx_r     <= BEAT_ZERO;
      addr_r    <= {ADDR_WIDTH{1'b0}};
      data_r    <= {DATA_WIDTH{1'b0}};
      be_r      <= {DW_B{1'b0}};
      req_r     <= 1'b0;
      valid_r   <= 1'b0;
      start_r   <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      req_r   <= ld_issue_s;
      valid_r <= st_issue_s;
      start_r <= (ld_issue_s | st_issue_s) & (beat_idx_s == BEAT_ZERO);
      busy_r  <= (state_s != IDLE);
      done_r  <= (state_s == FIN);
      if (accept_s) begin
        stride_r  <= cmd_stride;
        beats_r   <= cmd_beats;
        be_last_r <= cmd_be_last;
        acc_r     <= cmd_base;
        idx_r     <= BEAT_ZERO;
      end
      if (ld_issue_s || st_issue_s) begin
        addr_r <= beat_addr_s;
        acc_r  <= beat_addr_s + beat_stride_s;
        idx_r  <= beat_idx_s + BEAT_ONE;
        be_r   <= (st_issue_s && beat_last_s) ? be_last_r : BE_ALL;
      end
      if (st_issue_s) begin
        data_r <= st_data;
      end
    end
  end

  assign rvv.rvv_addr_out  = addr_r;
  assign rvv.rvv_data_out  = data_r;
  assign rvv.rvv_be_out    = be_r;
  assign rvv.rvv_req_out   = req_r;
  assign rvv.rvv_valid_out = valid_r;
  assign rvv.rvv_start_out = start_r;
  assign busy              = busy_r;
  assign done              = done_r;

endmodule

// File: doc/vec_lsu_agen.md
# vec_lsu_agen

Vector load/store address generator that sits directly upstream of `mem_queue`. It accepts one vector memory command at a time from the vector issue stage and expands it into per-beat 64-bit requests on the `rvv_*` request port of `mem_queue`. Each beat carries an address and, for stores, data and byte enables. The block then holds the command open until `mem_queue` reports load or store completion, and signals `done` to the issue stage.

## Interface
- `ADDR_WIDTH`, 32: byte address width; matches `mem_queue` `MBUS_ADDR_WIDTH`.
- `DATA_WIDTH`, 64: beat width; matches `RVV_DATA_WIDTH`.
- `DW_B`, `DATA_WIDTH>>3`: byte enables per beat.
- `BEAT_BITS`, 5: beat-count width; maximum of 31 beats per command, which fits the 32-entry queue FIFOs.

Ports (name, direction, width, meaning):
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  a command is offered.
- `cmd_ready`  out  1  the block accepts a command; high only in IDLE.
- `cmd_store`  in  1  1 = store, 0 = load.
- `cmd_base`  in  ADDR_WIDTH  byte address of beat 0.
- `cmd_stride`  in  ADDR_WIDTH  byte distance between consecutive beats, two's complement.
- `cmd_beats`  in  BEAT_BITS  number of beats N.
- `cmd_be_last`  in  DW_B  byte enables for the final store beat.
- `st_data`  in  DATA_WIDTH  store data from the vector register file.
- `st_valid`  in  1  `st_data` is valid.
- `st_ready`  out  1  high only in STORE.
- `rvv_addr_out`  out  ADDR_WIDTH  beat address.
- `rvv_data_out`  out  DATA_WIDTH  store beat data.
- `rvv_valid_out`  out  1  store beat strobe.
- `rvv_req_out`  out  1  load beat strobe.
- `rvv_start_out`  out  1  marks beat 0 of a command.
- `rvv_be_out`  out  DW_B  beat byte enables.
- `rvv_done_ld`  in  1  completion indication from `mem_queue` for loads.
- `rvv_done_st`  in  1  completion indication from `mem_queue` for stores.
- `busy`  out  1  the block is not in IDLE.
- `done`  out  1  one-cycle pulse when a command retires.

## Operation
- FSM states: IDLE, LOAD_REQ, LOAD_WAIT, STORE, STORE_WAIT, FIN.
- IDLE: on `cmd_valid & cmd_ready`, latch all command fields and clear the beat counter `i` and the address accumulator `acc` (`acc = cmd_base`).
  - `cmd_beats == 0` → go to FIN.
  - Otherwise → go to LOAD_REQ or STORE according to `cmd_store`.
- LOAD_REQ: issue one beat per cycle with no gaps. Gapless issue is required because `mem_queue` measures burst length from consecutive `rvv_req_out`.
  - Each beat drives `rvv_addr_out = acc` and `rvv_be_out` all ones, then updates `acc += stride` and `i += 1`.
  - After beat N-1 → go to LOAD_WAIT.
- LOAD_WAIT: when `rvv_done_ld == 1` → go to FIN. `rvv_done_ld` is ignored in every other state.
- STORE: `st_ready = 1`. Each `st_valid & st_ready` issues one beat:
  - `rvv_valid_out = 1`, `rvv_data_out = st_data`, `rvv_addr_out = acc`.
  - `rvv_be_out` = all ones, except `cmd_be_last` when `i == N-1`.
  - Gaps between beats are allowed.
  - After beat N-1 → go to STORE_WAIT.
- STORE_WAIT: when `rvv_done_st == 1` → go to FIN.
- FIN: `done = 1` for one cycle → go to IDLE.
- `rvv_start_out` is high on beat 0 of each command only, together with `rvv_req_out` or `rvv_valid_out`.
- Address arithmetic is modulo 2^ADDR_WIDTH. Wrap-around is silent. A negative stride decrements the address.
- `st_valid` outside STORE is ignored, and no data is consumed.
- `rst` in any state:
  - Next edge: FSM returns to IDLE and every strobe (`rvv_req_out`, `rvv_valid_out`, `rvv_start_out`, `done`) is low.
  - The partial command is discarded and no `done` is produced for it.

## Timing
- All `rvv_*` outputs, `busy`, and `done` are registered.
- `cmd_ready` and `st_ready` are decoded combinationally from state.
- Reset values: `rvv_addr_out=0`, `rvv_data_out=0`, `rvv_be_out=0`, all strobes 0, `busy=0`, `done=0`, state IDLE.
- Load accepted at edge T:
  - Beat k is on `rvv_req_out` in cycle T+1+k.
  - The last beat is in cycle T+N.
  - LOAD_WAIT begins in cycle T+N+1.
- Store beat accepted (`st_valid & st_ready`) in cycle t appears on `rvv_valid_out` in cycle t+1.
- `done` is high in the cycle after `rvv_done_*` is sampled high in a WAIT state.
- Zero-beat command accepted at T: `done` is high in cycle T+1, with no `rvv_*` strobes.
- `cmd_ready` is low from the accept edge until the cycle after FIN, so back-to-back commands are separated by at least one IDLE cycle.

## Test plan
- Load: base 0x1000, stride 8, N=4 → `rvv_req_out` high for 4 consecutive cycles with addresses 0x1000, 0x1008, 0x1010, 0x1018 and `rvv_start_out` on the first only. With `rvv_done_ld` pulsed 10 cycles later → `done` asserts one cycle after it.
- Store: base 0x2000, stride 8, N=3, `cmd_be_last=0x0F`, `st_valid` low for 2 cycles between beats 1 and 2 → `rvv_valid_out` beats carry addresses 0x2000, 0x2008, 0x2010 with be FF, FF, 0F. Data matches the input order. `done` follows `rvv_done_st`.
- Wrap and negative stride: base 0xFFFF_FFF8, stride 16, N=2 → addresses 0xFFFF_FFF8 then 0x0000_0008. Base 0x100, stride -8, N=3 → 0x100, 0xF8, 0xF0.
- Zero beats: `cmd_beats=0` → no strobes, and `done` is high exactly one cycle after accept.
- Reset mid-operation: assert `rst` during beat 2 of a 10-beat load → strobes are low at the next edge, `busy=0`, no `done`. A subsequent 2-beat load then runs normally from beat 0 with `rvv_start_out` set.
- Spurious completion: `rvv_done_ld` pulsed during LOAD_REQ → ignored, and the FSM still waits in LOAD_WAIT for the next `rvv_done_ld`.
